// File: rtl/spi_mem_bridge_slave.sv
// ---------------------------------------------------------------------------
// spi_mem_bridge_slave
// SPI responder (mode 0, 16-bit words, one word per chip-select low period)
// that turns register-read, memory-read and memory-write command sequences
// into single-cycle strobes on the SDRAM controller host port.
//
// Optional feature macro: SPI_BRIDGE_TIMEOUT_EN
//   defined   : a partial command is aborted after TIMEOUT_CYCLES clk cycles
//               of chip-select-high idle time.
//   undefined : a partial command waits indefinitely.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   spi_sck/cs/mosi   SPI inputs, asynchronous to clk
//   spi_miso          SPI reply bit (combinational from raw cs and tx shifter)
//   mem_wr_*          write address/data and one-cycle write strobe
//   mem_rd_*          read address/strobe, read data and its valid pulse
//   mem_busy          controller busy; strobes are held off while high
//   cmd_error         one-cycle pulse on every protocol error
// ---------------------------------------------------------------------------
module spi_mem_bridge_slave #(
   parameter logic [15:0] ID_VALUE       = 16'hC4B5,
   parameter int          SYNC_STAGES    = 2,
   parameter int          TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        spi_sck,
   input  logic        spi_cs,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic [31:0] mem_wr_addr,
   output logic [15:0] mem_wr_data,
   output logic        mem_wr_enable,
   output logic [31:0] mem_rd_addr,
   output logic        mem_rd_enable,
   input  logic [15:0] mem_rd_data,
   input  logic        mem_rd_ready,
   input  logic        mem_busy,
   output logic        cmd_error
);

   typedef enum logic [3:0] {
      IDLE, RADDR_LO, RADDR_HI, WADDR_LO, WADDR_HI, WDATA,
      RD_ISSUE, RD_WAIT, WR_ISSUE
   } state_t;

   state_t                 state_r;
   logic [SYNC_STAGES-1:0] sck_sync_r, cs_sync_r, mosi_sync_r;
   logic                   sck_prev_r, cs_prev_r;
   logic [15:0]            rx_shift_r, tx_shift_r, data_r, last_rd_data_r, err_count_r;
   logic [4:0]             bit_cnt_r;
   logic [31:0]            addr_r;

   logic        sck_s, cs_s, mosi_s, sck_rise_s, sck_fall_s, cs_rise_s;
   logic        word_valid_s, word_err_s, timeout_s, err_s;
   logic        issue_state_s, collect_state_s, rd_pending_s, wr_pending_s;
   logic [15:0] reply_s;

   // Register file seen by the 0x80 read command.
   function automatic logic [15:0] reg_read(input logic [7:0] a, input logic rdp,
                                            input logic wrp, input logic busy,
                                            input logic [15:0] last_rd, input logic [15:0] errs);
      case (a)
         8'h00:   reg_read = ID_VALUE;
         8'h01:   reg_read = {13'b0, rdp, wrp, busy};
         8'h02:   reg_read = last_rd;
         8'h03:   reg_read = errs;
         default: reg_read = 16'h0000;
      endcase
   endfunction

   assign spi_miso = spi_cs ? 1'b0 : tx_shift_r[15];

   // Edge detection, state classification and word-end decode.
   always_comb begin
      sck_s           = sck_sync_r[SYNC_STAGES-1];
      cs_s            = cs_sync_r[SYNC_STAGES-1];
      mosi_s          = mosi_sync_r[SYNC_STAGES-1];
      sck_rise_s      = sck_s & ~sck_prev_r;
      sck_fall_s      = ~sck_s & sck_prev_r;
      cs_rise_s       = cs_s & ~cs_prev_r;
      word_valid_s    = cs_rise_s && (bit_cnt_r == 5'd16);
      rd_pending_s    = (state_r == RD_ISSUE) || (state_r == RD_WAIT);
      wr_pending_s    = (state_r == WR_ISSUE);
      issue_state_s   = rd_pending_s || wr_pending_s;
      collect_state_s = (state_r == RADDR_LO) || (state_r == RADDR_HI) ||
                        (state_r == WADDR_LO) || (state_r == WADDR_HI) || (state_r == WDATA);
      reply_s    = 16'h0000;
      word_err_s = 1'b0;
      if (cs_rise_s && !word_valid_s) begin
         word_err_s = 1'b1;
      end else if (word_valid_s && (rx_shift_r[15:8] == 8'h80) && (state_r == IDLE || issue_state_s)) begin
         // Register reads are also served while a memory op is pending, so the
         // pending/busy status register can actually be observed.
         reply_s = reg_read(rx_shift_r[7:0], rd_pending_s, wr_pending_s, mem_busy,
                            last_rd_data_r, err_count_r);
      end else if (word_valid_s && (state_r == IDLE)) begin
         word_err_s = (rx_shift_r[15:8] != 8'hC0) && (rx_shift_r[15:8] != 8'hC1);
      end else if (word_valid_s && issue_state_s) begin
         word_err_s = 1'b1;
      end else begin
         word_err_s = 1'b0;
      end
   end

`ifdef SPI_BRIDGE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt_r;

   // Timeout fires once the idle counter has reached its limit.
   always_comb begin
      timeout_s = collect_state_s && (idle_cnt_r == TW'(TIMEOUT_CYCLES));
   end

   // Idle counter: counts cs-high cycles while a command is partially received.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= '0;
      end else if (word_valid_s || !collect_state_s || timeout_s) begin
         idle_cnt_r <= '0;
      end else if (cs_s) begin
         idle_cnt_r <= idle_cnt_r + 1'b1;
      end
   end
`else
   // Without the timeout feature a partial command never expires.
   always_comb begin
      timeout_s = 1'b0;
   end
`endif

   // Combined error source for the pulse and the saturating counter.
   always_comb begin
      err_s = word_err_s | timeout_s;
   end

   // Synchronizers, SPI shifters, command FSM and host-port strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync_r     <= {SYNC_STAGES{1'b0}};
         cs_sync_r      <= {SYNC_STAGES{1'b1}};   // cs idles high: no false word end
         mosi_sync_r    <= {SYNC_STAGES{1'b0}};
         sck_prev_r     <= 1'b0;
         cs_prev_r      <= 1'b1;
         state_r        <= IDLE;
         rx_shift_r     <= 16'h0000;
         tx_shift_r     <= 16'h0000;
         bit_cnt_r      <= 5'd0;
         addr_r         <= 32'h0000_0000;
         data_r         <= 16'h0000;
         last_rd_data_r <= 16'h0000;
         err_count_r    <= 16'h0000;
         mem_wr_addr    <= 32'h0000_0000;
         mem_wr_data    <= 16'h0000;
         mem_wr_enable  <= 1'b0;
         mem_rd_addr    <= 32'h0000_0000;
         mem_rd_enable  <= 1'b0;
         cmd_error      <= 1'b0;
      end else begin
         sck_sync_r    <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
         cs_sync_r     <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
         mosi_sync_r   <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
         sck_prev_r    <= sck_s;
         cs_prev_r     <= cs_s;
         mem_wr_enable <= 1'b0;
         mem_rd_enable <= 1'b0;
         cmd_error     <= err_s;
         if (err_s && (err_count_r != 16'hFFFF)) begin
            err_count_r <= err_count_r + 16'd1;
         end
         if (!cs_s && sck_rise_s) begin
            rx_shift_r <= {rx_shift_r[14:0], mosi_s};
            if (bit_cnt_r != 5'd31) begin
               bit_cnt_r <= bit_cnt_r + 5'd1;
            end
         end
         if (!cs_s && sck_fall_s) begin
            tx_shift_r <= {tx_shift_r[14:0], 1'b0};
         end
         if (cs_rise_s) begin
            bit_cnt_r  <= 5'd0;
            tx_shift_r <= reply_s;
         end

         case (state_r)
            IDLE: begin
               if (word_valid_s && rx_shift_r[15:8] == 8'hC0) state_r <= RADDR_LO;
               else if (word_valid_s && rx_shift_r[15:8] == 8'hC1) state_r <= WADDR_LO;
               else state_r <= IDLE;
            end
            RADDR_LO: if (word_valid_s) begin addr_r[15:0]  <= rx_shift_r; state_r <= RADDR_HI; end
            RADDR_HI: if (word_valid_s) begin addr_r[31:16] <= rx_shift_r; state_r <= RD_ISSUE; end
            WADDR_LO: if (word_valid_s) begin addr_r[15:0]  <= rx_shift_r; state_r <= WADDR_HI; end
            WADDR_HI: if (word_valid_s) begin addr_r[31:16] <= rx_shift_r; state_r <= WDATA;    end
            WDATA:    if (word_valid_s) begin data_r        <= rx_shift_r; state_r <= WR_ISSUE; end
            RD_ISSUE: begin
               if (!mem_busy) begin
                  mem_rd_enable <= 1'b1;
                  mem_rd_addr   <= addr_r;
                  state_r       <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (mem_rd_ready) begin
                  last_rd_data_r <= mem_rd_data;
                  // Preload the reply only between words, never mid-shift.
                  if (cs_s) tx_shift_r <= mem_rd_data;
                  state_r <= IDLE;
               end
            end
            WR_ISSUE: begin
               if (!mem_busy) begin
                  mem_wr_enable <= 1'b1;
                  mem_wr_addr   <= addr_r;
                  mem_wr_data   <= data_r;
                  state_r       <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase

         // A malformed word or an expired partial command aborts to IDLE.
         if ((cs_rise_s && !word_valid_s) || timeout_s) begin
            state_r <= IDLE;
         end
      end
   end

endmodule
